// File: rtl/keypad_entry_if.sv
// Keypad pins plus the packed-BCD number-entry bus that feeds the seven-segment display.
interface keypad_entry_if;
  logic [3:0]  KEY_ROW;
  logic [3:0]  KEY_COL;
  logic [31:0] num;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  digit_cnt;
  logic        full;

  modport master (
    input  KEY_ROW,
    output KEY_COL, num, key_valid, key_code, digit_cnt, full
  );

  modport slave (
    output KEY_ROW,
    input  KEY_COL, num, key_valid, key_code, digit_cnt, full
  );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce and packed-BCD number entry.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_entry #(
  parameter int CLK_HZ             = 50_000_000,
  parameter int SCAN_HZ            = 1000,
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic           CLOCK_50,
  input  logic           RESET,
  keypad_entry_if.master kp
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    row_p0, row_p1;
  state_t        state;
  logic [1:0]    col, row_q;
  logic [3:0]    col_n;
  logic [DW-1:0] deb_cnt;
  logic [31:0]   num_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q, digit_cnt_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] REP_DELAY_LAST = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] REP_RATE_LAST  = RW'(REPEAT_RATE_TICKS - 1);
  logic [RW-1:0] rep_cnt;
  logic          rep_on;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS};
`endif

  assign tick = (tick_cnt == TICK_LAST);

  // Lowest-index active-low row wins when several rows are pressed together.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    return 2'd3;
  endfunction

  // Returns {digit_cnt, num} after applying one key action.
  function automatic logic [35:0] next_entry(input logic [3:0] code, input logic [3:0] cnt,
                                             input logic [31:0] n);
    logic [35:0] r;
    r = {cnt, n};
    if (code <= 4'd9) begin
      if (cnt < 4'd8) r = {cnt + 4'd1, n[27:0], code};
    end else if (code == 4'd10) begin
      r = '0;
    end else if (code == 4'd11) begin
      if (cnt != 4'd0) r = {cnt - 4'd1, 4'h0, n[31:4]};
    end
    return r;
  endfunction

  task automatic accept_key();
    key_valid_q <= 1'b1;
    key_code_q  <= {row_q, col};
    {digit_cnt_q, num_q} <= next_entry({row_q, col}, digit_cnt_q, num_q);
  endtask

  task automatic advance_col();
    col   <= col + 2'd1;
    col_n <= {col_n[2:0], col_n[3]};
    state <= SCAN;
  endtask

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      tick_cnt    <= '0;
      row_p0      <= 4'hF;
      row_p1      <= 4'hF;
      state       <= SCAN;
      col         <= 2'd0;
      col_n       <= 4'b1110;
      row_q       <= 2'd0;
      deb_cnt     <= '0;
      num_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      digit_cnt_q <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt     <= '0;
      rep_on      <= 1'b0;
`endif
    end else begin
      // Stage p0/p1: two-flop synchronizer on the asynchronous row inputs
      row_p0      <= kp.KEY_ROW;
      row_p1      <= row_p0;
      key_valid_q <= 1'b0;
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;

      if (tick) begin
        case (state)
          SCAN: begin
            if (&row_p1) begin
              advance_col();
            end else begin
              row_q   <= low_row(row_p1);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (row_p1[row_q]) begin
              advance_col();
            end else if (deb_cnt == DEB_LAST) begin
              accept_key();
              deb_cnt <= '0;
              state   <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
              rep_on  <= 1'b0;
`endif
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          HELD: begin
            if (row_p1[row_q]) begin
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
              rep_on  <= 1'b0;
`endif
              if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                advance_col();
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else begin
              deb_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              // First repeat after the long delay, then at the shorter rate.
              if (!rep_on) begin
                if (rep_cnt == REP_DELAY_LAST) begin
                  accept_key();
                  rep_cnt <= '0;
                  rep_on  <= 1'b1;
                end else begin
                  rep_cnt <= rep_cnt + 1'b1;
                end
              end else if (rep_cnt == REP_RATE_LAST) begin
                accept_key();
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
`endif
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  assign kp.KEY_COL   = col_n;
  assign kp.num       = num_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.digit_cnt = digit_cnt_q;
  assign kp.full      = (digit_cnt_q == 4'd8);

endmodule
